// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Signed mode divides magnitudes and restores signs afterwards (truncating division).
module div_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem,
  output logic               div0,
  output logic               ovf
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0]  CNT_MAX = CW'(2 * W - 1);
  localparam logic [2*W-1:0] Q_LIM   = (2 * W)'(1) << (W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sgn;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic [2*W-1:0]  r_dvd;
  logic [W:0]      r_pr;
  logic [W-1:0]    r_dvs;

  logic [W:0]      w_shift;
  logic [W+1:0]    w_sub;
  logic            w_borrow;
  logic            w_accept;
  logic [2*W-1:0]  w_qc;
  logic [W-1:0]    w_rc;

  function automatic logic [2*W-1:0] f_abs_dvd(input logic s, input logic [2*W-1:0] x);
    return (s && x[2*W-1]) ? -x : x;
  endfunction

  function automatic logic [W-1:0] f_abs_dvs(input logic s, input logic [W-1:0] x);
    return (s && x[W-1]) ? -x : x;
  endfunction

  // Range check on the magnitude: a negative result may reach -2^(W-1), a positive one only 2^(W-1)-1.
  function automatic logic f_ovf(input logic s, input logic neg, input logic [2*W-1:0] qm);
    if (!s)
      return |qm[2*W-1:W];
    else if (neg)
      return qm > Q_LIM;
    else
      return qm >= Q_LIM;
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_shift  = {r_pr[W-1:0], r_dvd[2*W-1]};
  assign w_sub    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_borrow = w_sub[W+1];
  assign w_qc     = r_neg_q ? -r_dvd : r_dvd;
  assign w_rc     = r_neg_r ? -r_pr[W-1:0] : r_pr[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            r_sgn   <= sgn;
            r_neg_q <= sgn & (dividend[2*W-1] ^ divisor[W-1]);
            r_neg_r <= sgn & dividend[2*W-1];
            r_dz    <= (divisor == '0);
            r_cnt   <= CNT_MAX;
            r_state <= (divisor == '0) ? S_FIX : S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == '0)
            r_state <= S_FIX;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
          if (r_dz) begin
            quo  <= '0;
            rem  <= '0;
            div0 <= 1'b1;
            ovf  <= 1'b0;
          end else begin
            quo  <= w_qc[W-1:0];
            rem  <= w_rc;
            div0 <= 1'b0;
            ovf  <= f_ovf(r_sgn, r_neg_q, r_dvd);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: the dividend register shifts out dividend bits and shifts in quotient bits.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dvd <= f_abs_dvd(sgn, dividend);
      r_dvs <= f_abs_dvs(sgn, divisor);
      r_pr  <= '0;
    end else if (r_state == S_RUN) begin
      r_dvd <= {r_dvd[2*W-2:0], ~w_borrow};
      r_pr  <= w_borrow ? w_shift : w_sub[W:0];
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, div0, ovf;
  logic [15:0] quo, rem;

  logic        start8, sgn8;
  logic [15:0] dividend8;
  logic [7:0]  divisor8;
  logic        busy8, done8, div08, ovf8;
  logic [7:0]  quo8, rem8;

  int n_chk = 0;
  int n_err = 0;

  div_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .div0(div0), .ovf(ovf)
  );

  div_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quo(quo8), .rem(rem8), .div0(div08), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit s, input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output bit z, output bit o);
    longint qq, rr;
    if (b == 16'd0) begin
      q = 16'd0; r = 16'd0; z = 1'b1; o = 1'b0;
    end else begin
      z = 1'b0;
      if (!s) begin
        qq = longint'({32'd0, a}) / longint'({48'd0, b});
        rr = longint'({32'd0, a}) % longint'({48'd0, b});
        o  = (qq > 65535);
      end else begin
        qq = longint'($signed(a)) / longint'($signed(b));
        rr = longint'($signed(a)) % longint'($signed(b));
        o  = (qq > 32767) || (qq < -32768);
      end
      q = qq[15:0];
      r = rr[15:0];
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                        input logic [15:0] b, input bit mid);
    logic [15:0] eq, er;
    bit ez, eo, got;
    int cyc, bc;
    model(s, a, b, eq, er, ez, eo);
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    chk({tag, ".busy_acc"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0; sgn = 1'($urandom); dividend = $urandom; divisor = 16'($urandom);
    cyc = 0; bc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      cyc++;
      if (busy) bc++;
      if (done) got = 1'b1;
      else begin
        if (mid && cyc == 10) begin
          start = 1'b1; dividend = $urandom; divisor = 16'($urandom_range(1, 65535));
        end
        if (mid && cyc == 12) start = 1'b0;
        @(negedge clk);
      end
    end
    chk({tag, ".lat"},  64'(cyc), ez ? 64'd2 : 64'd34);
    chk({tag, ".busy"}, 64'(bc),  ez ? 64'd1 : 64'd33);
    chk({tag, ".quo"},  64'(quo),  64'(eq));
    chk({tag, ".rem"},  64'(rem),  64'(er));
    chk({tag, ".div0"}, 64'(div0), 64'(ez));
    chk({tag, ".ovf"},  64'(ovf),  64'(eo));
  endtask

  initial begin
    bit seen;
    int cyc8;
    logic [31:0] a;
    logic [15:0] b;
    bit s;
    clk = 1'b0; rst = 1'b0; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; sgn8 = 1'b0; dividend8 = '0; divisor8 = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.quo",  64'(quo),  64'd0);
    chk("reset.rem",  64'(rem),  64'd0);
    chk("reset.flags", {62'd0, div0, ovf}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("unsigned_100000_7", 1'b0, 32'h000186A0, 16'h0007, 1'b0);
    chk("direct.quo", 64'(quo), 64'h37CD);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    run_op("signed_m7_2", 1'b1, 32'hFFFFFFF9, 16'h0002, 1'b0);
    chk("direct.quo_neg", 64'(quo), 64'hFFFD);
    @(negedge clk);
    run_op("signed_7_m2", 1'b1, 32'h00000007, 16'hFFFE, 1'b0);
    @(negedge clk);
    run_op("div_by_zero", 1'b1, 32'h12345678, 16'h0000, 1'b0);
    @(negedge clk);
    run_op("ovf_unsigned", 1'b0, 32'h00010000, 16'h0001, 1'b0);
    @(negedge clk);
    run_op("ovf_signed_pos", 1'b1, 32'h00008000, 16'h0001, 1'b0);
    @(negedge clk);
    run_op("signed_minval", 1'b1, 32'hFFFF8000, 16'h0001, 1'b0);
    @(negedge clk);
    run_op("signed_mostneg", 1'b1, 32'h80000000, 16'hFFFF, 1'b0);
    @(negedge clk);
    run_op("mid_start", 1'b0, 32'h0000FFFF, 16'h0010, 1'b1);
    run_op("back_to_back", 1'b0, 32'h00001000, 16'h0003, 1'b0);
    run_op("b2b_div0", 1'b0, 32'h00000005, 16'h0000, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom >> $urandom_range(0, 31);
      if (s && $urandom_range(0, 1) == 1) a = -a;
      b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 15);
      run_op($sformatf("rand%0d", i), s, a, b, (i % 7) == 3);
      if ((i % 5) != 4) @(negedge clk);
    end
    @(negedge clk);

    start = 1'b1; sgn = 1'b0; dividend = 32'h00FF00FF; divisor = 16'h0013;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.quo",  64'(quo),  64'd0);
    chk("midrst.rem",  64'(rem),  64'd0);
    chk("midrst.flags", {62'd0, div0, ovf}, 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("midrst.no_done", 64'(seen), 64'd0);

    start8 = 1'b1; sgn8 = 1'b0; dividend8 = 16'd200; divisor8 = 8'd10;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0; dividend8 = 16'hFFFF; divisor8 = 8'd1;
    cyc8 = 1;
    while (!done8 && cyc8 < 100) begin
      @(negedge clk);
      cyc8++;
    end
    chk("w8.lat", 64'(cyc8), 64'd18);
    chk("w8.quo", 64'(quo8), 64'd20);
    chk("w8.rem", 64'(rem8), 64'd0);
    chk("w8.flags", {62'd0, div08, ovf8}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
